// File: rtl/pinwheel_uart.sv
// Memory-mapped 8N1 UART on the pinwheel bus (0xC region): TX/RX FIFOs,
// sticky status flags and a programmable bit period latched per frame.
module pinwheel_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8
) (
  input  logic        clock,
  input  logic        reset_in_n,
  input  logic        bus_cs,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wmask,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] rdata,
  output logic        uart_tx,
  input  logic        uart_rx
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_st_e;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16], bus_wmask[3:2]};

  // Bus decode
  logic [1:0] sel;
  logic       wr, rd;
  assign sel = bus_addr[3:2];
  assign wr  = bus_cs & bus_wren;
  assign rd  = bus_cs & bus_rden;

  logic [15:0] div_q, div_d, div_wr;
  logic        rx_ovf_q, tx_ovf_q, ferr_q;
  logic [2:0]  w1c;
  logic [31:0] rdata_q, rdata_d;

  // FIFOs
  logic [7:0]   tx_mem_q [TX_DEPTH];
  logic [7:0]   rx_mem_q [RX_DEPTH];
  logic [TAW:0] tx_wp_q, tx_rp_q;
  logic [RAW:0] rx_wp_q, rx_rp_q;
  logic         tx_empty, tx_full, rx_empty, rx_full;
  logic         tx_push_req, tx_push, tx_pop, tx_ovf_set;
  logic         rx_push_req, rx_push, rx_pop, rx_ovf_set, ferr_set;
  logic [7:0]   tx_head, rx_head;

  assign tx_empty = tx_wp_q == tx_rp_q;
  assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
  assign rx_empty = rx_wp_q == rx_rp_q;
  assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
  assign tx_head  = tx_mem_q[tx_rp_q[TAW-1:0]];
  assign rx_head  = rx_mem_q[rx_rp_q[RAW-1:0]];

  // TX FSM state
  tx_st_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_zero, tx_busy;

  // RX FSM state
  rx_st_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, rx_zero;

  assign tx_zero = tx_cnt_q == 16'd0;
  assign rx_zero = rx_cnt_q == 16'd0;
  assign rx_fall = rx_s3_q & ~rx_s2_q;

  // Push succeeds on a full FIFO only if the same cycle pops
  assign tx_push_req = wr && (sel == 2'd0) && bus_wmask[0];
  assign tx_pop      = (tx_st_q == TX_IDLE) && !tx_empty;
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_ovf_set  = tx_push_req && tx_full && !tx_pop;
  assign rx_pop      = rd && (sel == 2'd0) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovf_set  = rx_push_req && rx_full && !rx_pop;

  assign w1c = (wr && (sel == 2'd1) && bus_wmask[0]) ? bus_wdata[7:5] : 3'b000;

  always_comb begin
    div_wr = {bus_wmask[1] ? bus_wdata[15:8] : div_q[15:8],
              bus_wmask[0] ? bus_wdata[7:0]  : div_q[7:0]};
    div_d  = div_q;
    if (wr && (sel == 2'd2) && (|bus_wmask[1:0]) && (div_wr >= 16'd4))
      div_d = div_wr;
  end

  always_comb begin
    rdata_d = 32'd0;
    if (rd) begin
      case (sel)
        2'd0:    rdata_d = rx_empty ? 32'h100 : {24'd0, rx_head};
        2'd1:    rdata_d = {24'd0, ferr_q, tx_ovf_q, rx_ovf_q, tx_busy,
                            rx_full, rx_empty, tx_empty, tx_full};
        2'd2:    rdata_d = {16'd0, div_q};
        default: rdata_d = 32'd0;
      endcase
    end
  end

  // TX next state and datapath
  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    case (tx_st_q)
      TX_IDLE: if (!tx_empty) begin
        tx_st_d  = TX_START;
        tx_sh_d  = tx_head;
        tx_div_d = div_q;
        tx_cnt_d = div_q - 16'd1;
        tx_bit_d = 3'd0;
      end
      TX_START: begin
        tx_cnt_d = tx_zero ? tx_div_q - 16'd1 : tx_cnt_q - 16'd1;
        if (tx_zero) tx_st_d = TX_DATA;
      end
      TX_DATA: begin
        tx_cnt_d = tx_zero ? tx_div_q - 16'd1 : tx_cnt_q - 16'd1;
        if (tx_zero) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_d = tx_cnt_q - 16'd1;
        if (tx_zero) tx_st_d = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_busy = tx_st_q != TX_IDLE;
    uart_tx = 1'b1;
    if (tx_st_q == TX_START)     uart_tx = 1'b0;
    else if (tx_st_q == TX_DATA) uart_tx = tx_sh_q[0];
  end

  // RX next state and datapath; START waits half a bit to sample mid-bit
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    case (rx_st_q)
      RX_IDLE: if (rx_fall) begin
        rx_st_d  = RX_START;
        rx_div_d = div_q;
        rx_cnt_d = (div_q >> 1) - 16'd1;
      end
      RX_START: begin
        rx_cnt_d = rx_zero ? rx_div_q - 16'd1 : rx_cnt_q - 16'd1;
        rx_bit_d = 3'd0;
        if (rx_zero) rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        rx_cnt_d = rx_zero ? rx_div_q - 16'd1 : rx_cnt_q - 16'd1;
        if (rx_zero) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q - 16'd1;
        if (rx_zero) rx_st_d = rx_s2_q ? RX_IDLE : RX_WAIT;
      end
      RX_WAIT: if (rx_s2_q) rx_st_d = RX_IDLE;
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push_req = (rx_st_q == RX_STOP) && rx_zero && rx_s2_q;
    ferr_set    = (rx_st_q == RX_STOP) && rx_zero && !rx_s2_q;
  end

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wp_q[TAW-1:0]] <= bus_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wp_q[RAW-1:0]] <= rx_sh_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_in_n) begin
      div_q    <= DIV_RST;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_ovf_q <= 1'b0;
      tx_ovf_q <= 1'b0;
      ferr_q   <= 1'b0;
      rdata_q  <= 32'd0;
      tx_st_q  <= TX_IDLE;
      tx_cnt_q <= 16'd0;
      tx_div_q <= DIV_RST;
      tx_bit_q <= 3'd0;
      tx_sh_q  <= 8'd0;
      rx_st_q  <= RX_IDLE;
      rx_cnt_q <= 16'd0;
      rx_div_q <= DIV_RST;
      rx_bit_q <= 3'd0;
      rx_sh_q  <= 8'd0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
    end else begin
      div_q    <= div_d;
      tx_wp_q  <= tx_wp_q + (TAW+1)'(tx_push);
      tx_rp_q  <= tx_rp_q + (TAW+1)'(tx_pop);
      rx_wp_q  <= rx_wp_q + (RAW+1)'(rx_push);
      rx_rp_q  <= rx_rp_q + (RAW+1)'(rx_pop);
      // set beats a same-cycle W1C clear
      rx_ovf_q <= (rx_ovf_q & ~w1c[0]) | rx_ovf_set;
      tx_ovf_q <= (tx_ovf_q & ~w1c[1]) | tx_ovf_set;
      ferr_q   <= (ferr_q   & ~w1c[2]) | ferr_set;
      rdata_q  <= rdata_d;
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_s1_q  <= uart_rx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_pinwheel_uart.sv
// Directed/randomized bench for pinwheel_uart at 4 clocks per bit, checked
// against a frame-level model of the serial line and FIFO contents.
module tb_pinwheel_uart;
  localparam int DIV = 4;

  logic        clock = 1'b0;
  logic        reset_in_n, bus_cs, bus_wren, bus_rden, uart_rx;
  logic [31:0] bus_addr, bus_wdata, rdata;
  logic [3:0]  bus_wmask;
  logic        uart_tx;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  pinwheel_uart #(.CLKS_PER_BIT(DIV), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clock(clock), .reset_in_n(reset_in_n), .bus_cs(bus_cs), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_wren(bus_wren),
    .bus_rden(bus_rden), .rdata(rdata), .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_cs = 1; bus_wren = 1; bus_addr = {28'd0, a, 2'b00}; bus_wdata = d; bus_wmask = m;
    step(1);
    bus_cs = 0; bus_wren = 0; bus_wmask = 0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus_cs = 1; bus_rden = 1; bus_addr = {28'd0, a, 2'b00};
    step(1);
    d = rdata;
    bus_cs = 0; bus_rden = 0;
  endtask

  function automatic logic [31:0] sw(bit txf, bit txe, bit rxe, bit rxf, bit busy,
                                     bit rxo, bit txo, bit fe);
    return {24'd0, fe, txo, rxo, busy, rxf, rxe, txe, txf};
  endfunction

  // Line level k cycles after the write edge of a byte into an idle transmitter
  function automatic logic tx_expect(logic [7:0] b, int k);
    if (k >= 1 && k <= DIV) return 1'b0;
    if (k > DIV && k <= 9*DIV) return b[(k-DIV-1)/DIV];
    return 1'b1;
  endfunction

  // Decode one frame from uart_tx by mid-bit sampling
  task automatic tx_capture(input int div, output logic [7:0] b, output logic ok, output int t0);
    int n = 0;
    b = 8'd0; ok = 1'b0; t0 = 0;
    while (uart_tx !== 1'b0 && n < 2000) begin step(1); n++; end
    if (uart_tx !== 1'b0) return;
    t0 = cyc;
    step(div/2);
    if (uart_tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin step(div); b[i] = uart_tx; end
    step(div);
    ok = (uart_tx === 1'b1);
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stopb);
    uart_rx = 1'b0; step(DIV);
    for (int i = 0; i < 8; i++) begin uart_rx = b[i]; step(DIV); end
    uart_rx = stopb; step(DIV);
    uart_rx = 1'b1;
  endtask

  logic [31:0] d;
  logic [7:0]  b, rb, txb [10], cb [9];
  logic        cok [9];
  logic [7:0]  rxq [$];
  logic [7:0]  c1, c2;
  logic        ok1, ok2, stay_hi;
  int          t1, t2, ct;

  initial begin
    reset_in_n = 0; bus_cs = 1; bus_rden = 1; bus_wren = 0; bus_addr = 32'h4;
    bus_wdata = 0; bus_wmask = 0; uart_rx = 1;
    step(3);
    check("reset rdata", rdata, 32'd0);
    check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
    reset_in_n = 1; bus_cs = 0; bus_rden = 0;
    step(2);
    bus_rd(2'd1, d); check("reset status", d, 32'h06);
    bus_rd(2'd2, d); check("reset clkdiv", d, 32'd4);

    // Single frames: line waveform and busy timing
    for (int t = 0; t < 3; t++) begin
      b = (t == 0) ? 8'h55 : 8'($urandom);
      bus_wr(2'd0, {24'd0, b}, 4'h1);
      bus_cs = 1; bus_rden = 1; bus_addr = 32'h4;
      for (int k = 1; k <= 42; k++) begin
        step(1);
        check($sformatf("tx line b%0d k%0d", t, k), {31'd0, uart_tx}, {31'd0, tx_expect(b, k)});
        check($sformatf("tx busy b%0d k%0d", t, k), {31'd0, rdata[4]}, 32'(k >= 2 && k <= 41));
      end
      bus_cs = 0; bus_rden = 0;
    end

    // Burst of 10 writes: 9 accepted, 10th overflows
    for (int i = 0; i < 10; i++) txb[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 10; i++) bus_wr(2'd0, {24'd0, txb[i]}, 4'h1);
        bus_rd(2'd1, d); check("tx ovf status", d, sw(1,0,1,0,1,0,1,0));
        bus_wr(2'd1, 32'h40, 4'h1);
        bus_rd(2'd1, d); check("tx ovf w1c", d, sw(1,0,1,0,1,0,0,0));
      end
      begin
        for (int i = 0; i < 9; i++) tx_capture(DIV, cb[i], cok[i], ct);
      end
    join
    for (int i = 0; i < 9; i++) begin
      check($sformatf("burst byte %0d", i), {24'd0, cb[i]}, {24'd0, txb[i]});
      check($sformatf("burst stop %0d", i), {31'd0, cok[i]}, 32'd1);
    end
    step(5);
    bus_rd(2'd1, d); check("tx drained", d, sw(0,1,1,0,0,0,0,0));

    // RX single byte
    rx_send(8'hA3, 1'b1); step(2);
    bus_rd(2'd1, d); check("rx not empty", d, sw(0,1,0,0,0,0,0,0));
    bus_rd(2'd0, d); check("rx A3", d, 32'h0A3);
    bus_rd(2'd0, d); check("rx empty read", d, 32'h100);

    // Fill RX FIFO, then pop and push on the same edge while full
    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom); rxq.push_back(rb); rx_send(rb, 1'b1); step(2);
    end
    bus_rd(2'd1, d); check("rx full", d, sw(0,1,0,1,0,0,0,0));
    rb = 8'($urandom);
    fork
      rx_send(rb, 1'b1);
      begin
        step(40);
        bus_cs = 1; bus_rden = 1; bus_addr = 32'h0;
        step(1);
        d = rdata; bus_cs = 0; bus_rden = 0;
      end
    join
    check("rx pop on full push", d, {24'd0, rxq.pop_front()});
    rxq.push_back(rb);
    step(2);
    bus_rd(2'd1, d); check("rx full no ovf", d, sw(0,1,0,1,0,0,0,0));
    rx_send(8'($urandom), 1'b1); step(2);
    bus_rd(2'd1, d); check("rx ovf", d, sw(0,1,0,1,0,1,0,0));
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'd0, d); check($sformatf("rx fifo %0d", i), d, {24'd0, rxq.pop_front()});
    end
    bus_rd(2'd0, d); check("rx drained", d, 32'h100);
    bus_wr(2'd1, 32'h20, 4'h1);
    bus_rd(2'd1, d); check("rx ovf w1c", d, 32'h06);

    // Framing error and glitch
    rx_send(8'($urandom), 1'b0); step(3);
    bus_rd(2'd1, d); check("frame err", d, sw(0,1,1,0,0,0,0,1));
    bus_rd(2'd0, d); check("frame err no byte", d, 32'h100);
    bus_wr(2'd1, 32'h80, 4'h1);
    uart_rx = 1'b0; step(1); uart_rx = 1'b1; step(12);
    bus_rd(2'd1, d); check("glitch ignored", d, 32'h06);
    bus_rd(2'd0, d); check("glitch no byte", d, 32'h100);

    // Reset during DATA bit 3
    bus_wr(2'd0, 32'h000000F0, 4'h1);
    step(17);
    bus_wr(2'd2, 32'd6, 4'h3);
    reset_in_n = 0; bus_cs = 1; bus_rden = 1; bus_addr = 32'h4;
    step(1);
    check("midframe reset tx", {31'd0, uart_tx}, 32'd1);
    check("midframe reset rdata", rdata, 32'd0);
    reset_in_n = 1; bus_cs = 0; bus_rden = 0;
    bus_rd(2'd1, d); check("post reset status", d, 32'h06);
    bus_rd(2'd2, d); check("post reset clkdiv", d, 32'd4);
    stay_hi = 1'b1;
    for (int i = 0; i < 60; i++) begin step(1); if (uart_tx !== 1'b1) stay_hi = 1'b0; end
    check("post reset line idle", {31'd0, stay_hi}, 32'd1);

    // CLKDIV bounds and per-frame latching
    bus_wr(2'd2, 32'd2, 4'hF);
    bus_rd(2'd2, d); check("clkdiv 2 ignored", d, 32'd4);
    bus_wr(2'd2, 32'd3, 4'hF);
    bus_rd(2'd2, d); check("clkdiv 3 ignored", d, 32'd4);
    b = 8'($urandom); rb = 8'($urandom);
    fork
      begin
        bus_wr(2'd0, {24'd0, b}, 4'h1);
        bus_wr(2'd0, {24'd0, rb}, 4'h1);
        step(10);
        bus_wr(2'd2, 32'd8, 4'h3);
      end
      begin
        tx_capture(4, c1, ok1, t1);
        tx_capture(8, c2, ok2, t2);
      end
    join
    check("div4 frame byte", {24'd0, c1}, {24'd0, b});
    check("div4 frame stop", {31'd0, ok1}, 32'd1);
    check("div8 frame byte", {24'd0, c2}, {24'd0, rb});
    check("div8 frame stop", {31'd0, ok2}, 32'd1);
    check("frame spacing", 32'(t2 - t1), 32'd41);
    bus_rd(2'd2, d); check("clkdiv 8", d, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
